issue_hazard_scoreboard: RTL

Tracks in-flight register writes between instruction issue and register-file writeback, and stalls issue of any instruction whose sources or destination collide with a pending write. Sits directly downstream of the destination extractor. Consumes the extractor's destination flag and destination register for each issued instruction, plus the candidate instruction's source operand fields from the decoder. Produces the issue stall to the fetch/decode stage.

---
 rtl/issue_hazard_scoreboard.sv | 70 +++++++
 1 files changed

// File: rtl/issue_hazard_scoreboard.sv
// Issue hazard scoreboard: tracks pending register writes in a shift
// pipeline and stalls issue on RAW/WAW collisions with them.
module issue_hazard_scoreboard #(
  parameter int WB_LATENCY = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_issue_valid,
  input  logic       i_dest_flag,
  input  logic [2:0] i_dest,
  input  logic       i_src_a_flag,
  input  logic [2:0] i_src_a,
  input  logic       i_src_b_flag,
  input  logic [2:0] i_src_b,
  input  logic       i_flush,
  output logic       o_stall,
  output logic       o_issue,
  output logic [7:0] o_busy_mask,
  output logic [3:0] o_pending_count
);

  logic [WB_LATENCY-1:0]      vld_q, vld_d;
  logic [WB_LATENCY-1:0][2:0] dst_q, dst_d;
  logic [7:0]                 busy;
  logic [3:0]                 cnt;
  logic                       hazard;

  // Busy is a plain OR so duplicate dests in flight stay correct.
  always_comb begin
    busy = '0;
    cnt  = '0;
    for (int k = 0; k < WB_LATENCY; k++) begin
      if (vld_q[k]) busy[dst_q[k]] = 1'b1;
      cnt = cnt + {3'b000, vld_q[k]};
    end
  end

  assign hazard = (i_src_a_flag & busy[i_src_a])
                | (i_src_b_flag & busy[i_src_b])
                | (i_dest_flag  & busy[i_dest]);

  assign o_stall         = i_issue_valid & hazard;
  assign o_issue         = i_issue_valid & ~hazard & ~i_flush;
  assign o_busy_mask     = busy;
  assign o_pending_count = cnt;

  always_comb begin
    vld_d = '0;
    dst_d = dst_q;
    if (!i_flush) begin
      for (int k = 1; k < WB_LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        dst_d[k] = dst_q[k-1];
      end
      vld_d[0] = o_issue & i_dest_flag;
      dst_d[0] = i_dest;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
    end
  end

endmodule
